// File: rtl/tdes_pkg.sv
// rtl/tdes_pkg.sv - shared types, tables and permutations for the DES key schedule
package tdes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Which key slot feeds a pass and whether its subkeys run K16..K1
   typedef struct packed {
      logic [1:0] slot;
      logic       reverse;
   } pass_cfg_t;

   localparam int MAX_PASSES = 3;

   // Per-round left-rotate amounts, index 0 = round 1
   localparam logic [1:0] SHIFT_TAB [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   function automatic int num_passes(input int num_keys);
      return (num_keys == 1) ? 1 : MAX_PASSES;
   endfunction

   // Table bit n (1-based, MSB first) maps to key[64-n]
   function automatic logic [55:0] pc1(input logic [63:0] key);
      logic [55:0] cd;
      for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_TAB[i]];
      return cd;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] sk;
      for (int i = 0; i < 48; i++) sk[47 - i] = cd[56 - PC2_TAB[i]];
      return sk;
   endfunction

   // Rotates C and D halves independently by 1 or 2 positions
   function automatic logic [55:0] rotate_cd(input logic [55:0] cd, input logic left,
                                             input logic two);
      logic [27:0] c;
      logic [27:0] d;
      c = cd[55:28];
      d = cd[27:0];
      if (left) begin
         if (two) begin
            c = {c[25:0], c[27:26]};
            d = {d[25:0], d[27:26]};
         end else begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
      end else begin
         if (two) begin
            c = {c[1:0], c[27:2]};
            d = {d[1:0], d[27:2]};
         end else begin
            c = {c[0], c[27:1]};
            d = {d[0], d[27:1]};
         end
      end
      return {c, d};
   endfunction

   // EDE ordering: decrypt walks the keys backwards with directions flipped
   function automatic pass_cfg_t pass_select(input logic [1:0] pass, input logic decrypt,
                                             input logic three_key);
      pass_cfg_t cfg;
      case (pass)
         2'd0: begin
            cfg.slot    = (decrypt && three_key) ? 2'd2 : 2'd0;
            cfg.reverse = decrypt;
         end
         2'd1: begin
            cfg.slot    = 2'd1;
            cfg.reverse = !decrypt;
         end
         default: begin
            cfg.slot    = (!decrypt && three_key) ? 2'd2 : 2'd0;
            cfg.reverse = decrypt;
         end
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/des_cd_rotator.sv
// rtl/des_cd_rotator.sv - 56-bit C/D register with load and 1/2-bit rotate
module des_cd_rotator
   import tdes_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        load,
   input  logic [55:0] load_cd,
   input  logic        shift_en,
   input  logic        shift_left,
   input  logic        shift_two,
   output logic [55:0] cd
);

   logic [55:0] cd_q;

   // Load wins over rotate; otherwise hold
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cd_q <= '0;
      end else if (load) begin
         cd_q <= load_cd;
      end else if (shift_en) begin
         cd_q <= rotate_cd(cd_q, shift_left, shift_two);
      end
   end

   assign cd = cd_q;

endmodule

// File: rtl/tdes_key_schedule.sv
// rtl/tdes_key_schedule.sv - DES/3DES round subkey streamer with key slots
module tdes_key_schedule
   import tdes_pkg::*;
#(
   parameter int NUM_KEYS = 3,
   parameter int ROUNDS   = 16
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        key_load,
   input  logic [1:0]  key_sel,
   input  logic [63:0] key_in,
   input  logic        start,
   input  logic        decrypt,
   input  logic        abort,
   output logic [47:0] subkey,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [3:0]  subkey_round,
   output logic [1:0]  subkey_pass,
   output logic        subkey_last,
   output logic        busy,
   output logic        done,
   output logic        keys_ready
);

   localparam int         NUM_PASSES = num_passes(NUM_KEYS);
   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
   localparam logic [1:0] LAST_PASS  = 2'(NUM_PASSES - 1);
   localparam logic       THREE_KEY  = (NUM_KEYS == 3);

   state_t      state_q, state_d;
   logic [63:0] key_q [3];
   logic [2:0]  loaded_q;
   logic        decrypt_q;
   logic [1:0]  pass_q;
   logic [3:0]  round_q;
   logic        done_q;
   logic [55:0] cd;
   pass_cfg_t   cfg;
   logic [63:0] pass_key;
   logic [55:0] prep_cd;
   logic        shift_two;
   logic        cd_load, cd_shift, advance, pass_end, seq_end;

   assign keys_ready = &loaded_q[NUM_KEYS-1:0];

   // Key slots are writable only while idle so a running sequence sees stable keys
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < 3; i++) key_q[i] <= '0;
         loaded_q <= '0;
      end else if (state_q == IDLE && key_load) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_sel == 2'(i)) begin
               key_q[i]    <= key_in;
               loaded_q[i] <= 1'b1;
            end
         end
      end
   end

   // Pass key and rotate amount for the current pass/round
   always_comb begin
      cfg = pass_select(pass_q, decrypt_q, THREE_KEY);
      case (cfg.slot)
         2'd1:    pass_key = key_q[1];
         2'd2:    pass_key = key_q[2];
         default: pass_key = key_q[0];
      endcase
      prep_cd   = cfg.reverse ? pc1(pass_key)
                              : rotate_cd(pc1(pass_key), 1'b1, SHIFT_TAB[0] == 2'd2);
      shift_two = cfg.reverse ? (SHIFT_TAB[4'd15 - round_q] == 2'd2)
                              : (SHIFT_TAB[round_q + 4'd1] == 2'd2);
   end

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and per-cycle control decode; abort outranks everything
   always_comb begin
      state_d  = state_q;
      cd_load  = 1'b0;
      cd_shift = 1'b0;
      advance  = 1'b0;
      pass_end = 1'b0;
      seq_end  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && keys_ready && !abort) state_d = PREP;
         end
         PREP: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               cd_load = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (subkey_ready) begin
               advance = 1'b1;
               if (round_q == LAST_ROUND) begin
                  pass_end = 1'b1;
                  if (pass_q == LAST_PASS) begin
                     seq_end = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = PREP;
                  end
               end else begin
                  cd_shift = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Round/pass counters, latched mode and done pulse
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         decrypt_q <= 1'b0;
         pass_q    <= '0;
         round_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= seq_end;
         if (state_q == IDLE) begin
            pass_q  <= '0;
            round_q <= '0;
            if (state_d == PREP) decrypt_q <= decrypt;
         end else if (state_d == IDLE) begin
            pass_q  <= '0;
            round_q <= '0;
         end else if (pass_end) begin
            pass_q  <= pass_q + 2'd1;
            round_q <= '0;
         end else if (advance) begin
            round_q <= round_q + 4'd1;
         end
      end
   end

   des_cd_rotator u_rotator (
      .clk        (clk),
      .n_rst      (n_rst),
      .load       (cd_load),
      .load_cd    (prep_cd),
      .shift_en   (cd_shift),
      .shift_left (!cfg.reverse),
      .shift_two  (shift_two),
      .cd         (cd)
   );

   assign subkey       = pc2(cd);
   assign subkey_valid = (state_q == RUN);
   assign subkey_round = round_q;
   assign subkey_pass  = pass_q;
   assign subkey_last  = (state_q == RUN) && (pass_q == LAST_PASS) && (round_q == LAST_ROUND);
   assign busy         = (state_q != IDLE);
   assign done         = done_q;

endmodule

// File: tb/tb_tdes_key_schedule.sv
// tb/tb_tdes_key_schedule.sv - self-checking bench for tdes_key_schedule
module tb_tdes_key_schedule;

   localparam logic [63:0] K1 = 64'h133457799BBCDFF1;

   localparam int PC1_REF [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2_REF [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SHIFTS_REF [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   typedef struct packed {
      logic [47:0] sk;
      logic [3:0]  rnd;
      logic [1:0]  pas;
      logic        lst;
   } exp_t;

   typedef struct {
      int          which;
      logic        dec;
      logic [63:0] k1, k2, k3;
      int          low_pct;
      bit          anchor;
      logic [47:0] first, last;
   } vec_t;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        key_load1, key_load3, start1, start3;
   logic [1:0]  key_sel;
   logic [63:0] key_in;
   logic        decrypt, abort, subkey_ready;

   logic [47:0] sk1, sk3;
   logic [3:0]  r1, r3;
   logic [1:0]  p1, p3;
   logic        v1, v3, l1, l3, b1, b3, d1, d3, kr1, kr3;

   int          sel = 3;
   logic [47:0] m_sk;
   logic [3:0]  m_round;
   logic [1:0]  m_pass;
   logic        m_valid, m_last, m_busy, m_done;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   tdes_key_schedule #(.NUM_KEYS(1), .ROUNDS(16)) dut1 (
      .clk(clk), .n_rst(n_rst), .key_load(key_load1), .key_sel(key_sel), .key_in(key_in),
      .start(start1), .decrypt(decrypt), .abort(abort), .subkey(sk1), .subkey_valid(v1),
      .subkey_ready(subkey_ready), .subkey_round(r1), .subkey_pass(p1), .subkey_last(l1),
      .busy(b1), .done(d1), .keys_ready(kr1)
   );

   tdes_key_schedule #(.NUM_KEYS(3), .ROUNDS(16)) dut3 (
      .clk(clk), .n_rst(n_rst), .key_load(key_load3), .key_sel(key_sel), .key_in(key_in),
      .start(start3), .decrypt(decrypt), .abort(abort), .subkey(sk3), .subkey_valid(v3),
      .subkey_ready(subkey_ready), .subkey_round(r3), .subkey_pass(p3), .subkey_last(l3),
      .busy(b3), .done(d3), .keys_ready(kr3)
   );

   always_comb begin
      if (sel == 1) begin
         m_sk = sk1; m_round = r1; m_pass = p1; m_valid = v1;
         m_last = l1; m_busy = b1; m_done = d1;
      end else begin
         m_sk = sk3; m_round = r3; m_pass = p3; m_valid = v3;
         m_last = l3; m_busy = b3; m_done = d3;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Subkey n (1..16) from cumulative left shifts of C0/D0
   function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] k;
      int tot;
      for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_REF[i]];
      c = cd[55:28];
      d = cd[27:0];
      tot = 0;
      for (int j = 0; j < n; j++) tot += SHIFTS_REF[j];
      for (int j = 0; j < tot; j++) begin
         c = {c[26:0], c[27]};
         d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47 - i] = cd[56 - PC2_REF[i]];
      return k;
   endfunction

   task automatic push_expected(input int nk, input logic dec,
                                input logic [63:0] k1, input logic [63:0] k2,
                                input logic [63:0] k3);
      int np;
      logic [63:0] key;
      bit rev;
      exp_t e;
      np = (nk == 1) ? 1 : 3;
      for (int p = 0; p < np; p++) begin
         if (!dec) begin
            case (p)
               0: begin key = k1; rev = 0; end
               1: begin key = k2; rev = 1; end
               default: begin key = (nk == 2) ? k1 : k3; rev = 0; end
            endcase
         end else begin
            case (p)
               0: begin key = (nk == 3) ? k3 : k1; rev = 1; end
               1: begin key = k2; rev = 0; end
               default: begin key = k1; rev = 1; end
            endcase
         end
         for (int r = 0; r < 16; r++) begin
            e.sk  = ref_subkey(key, rev ? (16 - r) : (r + 1));
            e.rnd = 4'(r);
            e.pas = 2'(p);
            e.lst = (p == np - 1) && (r == 15);
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic load_key(input int which, input logic [1:0] slot, input logic [63:0] k);
      @(negedge clk);
      key_sel = slot;
      key_in  = k;
      if (which == 1) key_load1 = 1'b1;
      else            key_load3 = 1'b1;
      @(negedge clk);
      key_load1 = 1'b0;
      key_load3 = 1'b0;
   endtask

   task automatic run_seq(input int which, input logic dec, input int low_pct,
                          input int abort_pass, input int abort_round, input bit load_busy,
                          input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] k3,
                          output logic [47:0] first_sk, output logic [47:0] last_sk);
      int np, cyc, accepted, bubbles, dones, first_at;
      bit finished, aborted, stalled, rdy;
      exp_t cur, prev, e;
      np = (which == 1) ? 1 : 3;
      accepted = 0; bubbles = 0; dones = 0; first_at = -1;
      finished = 0; aborted = 0; stalled = 0; prev = '0;
      first_sk = '0; last_sk = '0;
      sel = which;
      sb_q.delete();
      push_expected(which, dec, k1, k2, k3);
      @(negedge clk);
      decrypt = dec;
      subkey_ready = 1'b1;
      if (which == 1) start1 = 1'b1;
      else            start3 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      decrypt = ~dec;
      cyc = 1;
      while (!finished && cyc < 3000) begin
         key_load1 = 1'b0;
         key_load3 = 1'b0;
         if (m_done) dones++;
         if (m_busy && !m_valid) bubbles++;
         rdy = ($urandom_range(99) >= low_pct);
         if (m_valid) begin
            cur = {m_sk, m_round, m_pass, m_last};
            if (first_at < 0) first_at = cyc;
            if (stalled) check("stall_hold", 64'(cur), 64'(prev));
            if (abort_pass == int'(m_pass) && abort_round == int'(m_round)) begin
               abort = 1'b1;
               aborted = 1;
               finished = 1;
               rdy = 1;
            end else if (rdy) begin
               if (sb_q.size() == 0) begin
                  check("scoreboard_empty", 64'd1, 64'd0);
                  finished = 1;
               end else begin
                  e = sb_q.pop_front();
                  check("subkey_stream", 64'(cur), 64'(e));
                  if (accepted == 0) first_sk = m_sk;
                  last_sk = m_sk;
                  accepted++;
                  if (e.lst) finished = 1;
               end
            end
            stalled = !rdy;
            prev = cur;
         end else begin
            stalled = 0;
         end
         subkey_ready = rdy;
         if (load_busy && cyc == 5) begin
            key_sel = 2'd0;
            key_in  = {$urandom(), $urandom()};
            if (which == 1) key_load1 = 1'b1;
            else            key_load3 = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      abort = 1'b0;
      key_load1 = 1'b0;
      key_load3 = 1'b0;
      subkey_ready = 1'b1;
      check("seq_complete", 64'(finished), 64'd1);
      if (aborted) begin
         check("abort_idle", {62'd0, m_valid, m_busy}, 64'd0);
         @(negedge clk);
         check("abort_no_done", {62'd0, m_done, m_valid}, 64'd0);
         check("abort_done_count", 64'(dones), 64'd0);
      end else begin
         check("first_latency", 64'(first_at), 64'd2);
         check("accept_count", 64'(accepted), 64'(16 * np));
         check("prep_bubbles", 64'(bubbles), 64'(np));
         check("early_done", 64'(dones), 64'd0);
         check("done_pulse", {61'd0, m_done, m_valid, m_busy}, 64'd4);
         @(negedge clk);
         check("done_width", 64'(m_done), 64'd0);
      end
      sb_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl [7];
      logic [47:0] fs, ls;
      logic [63:0] ra, rb, rc, rd, re, rf;

      ra = {$urandom(), $urandom()}; rb = {$urandom(), $urandom()};
      rc = {$urandom(), $urandom()}; rd = {$urandom(), $urandom()};
      re = {$urandom(), $urandom()}; rf = {$urandom(), $urandom()};
      tbl[0] = '{1, 1'b0, K1, 64'h0, 64'h0, 0,  1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
      tbl[1] = '{1, 1'b1, K1, 64'h0, 64'h0, 0,  1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
      tbl[2] = '{3, 1'b0, K1, 64'h0, 64'h0, 0,  1'b1, 48'h1B02EFFC7072, 48'h000000000000};
      tbl[3] = '{3, 1'b1, K1, 64'h0, 64'h0, 0,  1'b1, 48'h000000000000, 48'h1B02EFFC7072};
      tbl[4] = '{3, 1'b1, K1, 64'h0, 64'h0, 30, 1'b1, 48'h000000000000, 48'h1B02EFFC7072};
      tbl[5] = '{3, 1'b0, ra, rb, rc, 0,  1'b0, 48'h0, 48'h0};
      tbl[6] = '{3, 1'b1, rd, re, rf, 30, 1'b0, 48'h0, 48'h0};

      n_rst = 1'b0;
      key_load1 = 0; key_load3 = 0; start1 = 0; start3 = 0;
      key_sel = 0; key_in = 0; decrypt = 0; abort = 0; subkey_ready = 1;
      repeat (3) @(negedge clk);
      check("reset_dut1", 64'({sk1, v1, r1, p1, l1, b1, d1, kr1}), 64'd0);
      check("reset_dut3", 64'({sk3, v3, r3, p3, l3, b3, d3, kr3}), 64'd0);
      n_rst = 1'b1;

      load_key(1, 2'd0, K1);
      check("keys_ready_single", 64'(kr1), 64'd1);
      load_key(3, 2'd0, K1);
      @(negedge clk);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      @(negedge clk);
      check("start_unloaded_busy", {62'd0, b3, kr3}, 64'd0);
      load_key(3, 2'd1, 64'h0);
      @(negedge clk);
      key_sel = 2'd2; key_in = 64'h0; key_load3 = 1'b1; start3 = 1'b1;
      @(negedge clk);
      key_load3 = 1'b0; start3 = 1'b0;
      check("load_and_start_same_cycle", {62'd0, b3, kr3}, 64'd1);
      @(negedge clk);
      check("load_and_start_no_busy", 64'(b3), 64'd0);

      for (int i = 0; i < 7; i++) begin
         if (tbl[i].which == 1) begin
            load_key(1, 2'd0, tbl[i].k1);
         end else begin
            load_key(3, 2'd0, tbl[i].k1);
            load_key(3, 2'd1, tbl[i].k2);
            load_key(3, 2'd2, tbl[i].k3);
         end
         run_seq(tbl[i].which, tbl[i].dec, tbl[i].low_pct, -1, -1, 1'b0,
                 tbl[i].k1, tbl[i].k2, tbl[i].k3, fs, ls);
         if (tbl[i].anchor) begin
            check("anchor_first", 64'(fs), 64'(tbl[i].first));
            check("anchor_last", 64'(ls), 64'(tbl[i].last));
         end
      end

      load_key(3, 2'd0, ra);
      load_key(3, 2'd1, rb);
      load_key(3, 2'd2, rc);
      run_seq(3, 1'b0, 0, 1, 7, 1'b0, ra, rb, rc, fs, ls);
      run_seq(3, 1'b0, 0, -1, -1, 1'b0, ra, rb, rc, fs, ls);
      check("restart_first", 64'(fs), 64'(ref_subkey(ra, 1)));

      run_seq(3, 1'b1, 0, -1, -1, 1'b1, ra, rb, rc, fs, ls);
      run_seq(3, 1'b1, 0, -1, -1, 1'b0, ra, rb, rc, fs, ls);
      check("busy_load_ignored_last", 64'(ls), 64'(ref_subkey(ra, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
